// File: rtl/seg7_pkg.sv
// Shared constants, segment encoding and conversion-FSM states for the seven-segment scan driver.
// Latency: none (package only).
// Backpressure: none (package only).
package seg7_pkg;

  // Segment patterns, {a,b,c,d,e,f,g}, active-low
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // BCD digit to active-low segments; non-decimal codes go dark
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Decimal digits needed for a w-bit binary value, plus one spare:
  // ceil(w*log10(2)) + 1, using fixed-point log10(2) ~= 0.30103
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value load / status / display bus of the seven-segment scan driver.
// Latency: n/a (signal bundle).
// Backpressure: value_valid is ignored while busy is high; there is no queuing.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 10
);
  logic [BIN_WIDTH-1:0]  value;
  logic                  value_valid;
  logic                  blank;
  logic                  busy;
  logic                  overflow;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  // master loads values and observes the display; slave is the driver itself
  modport master (output value, value_valid, blank,
                  input  busy, overflow, seg, an);
  modport slave  (input  value, value_valid, blank,
                  output busy, overflow, seg, an);
endinterface

// File: rtl/seg7_digit_decode.sv
// One BCD digit plus blank/dash controls to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // dash wins over blank, blank wins over the digit value
  always_comb begin
    seg = digit_to_seg(bcd);
    if (blank) seg = SEG_BLANK;
    if (dash)  seg = SEG_DASH;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD (double dabble) conversion plus time-multiplexed active-low 7-seg digit scan.
// Latency: BIN_WIDTH+1 cycles from value_valid to display register update; seg/an registered.
// Backpressure: busy high during conversion; value_valid seen while busy is dropped.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 10,
  parameter int SCAN_DIV   = 50000,
  parameter int LZ_BLANK   = 1
) (
  input  logic clk,
  input  logic reset_n,
  seg7_scan_driver_if.slave bus
);

  // Accumulator keeps at least one digit above the displayed ones so overflow is always visible
  localparam int ACC_RAW = bcd_digits(BIN_WIDTH);
  localparam int ACC_D   = (ACC_RAW > NUM_DIGITS + 1) ? ACC_RAW : NUM_DIGITS + 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW      = $clog2(SCAN_DIV);
  localparam int BCW     = $clog2(BIN_WIDTH + 1);

  state_t                state, next_state;
  logic                  load;
  logic [BIN_WIDTH-1:0]  bin_sr;
  logic [ACC_D*4-1:0]    bcd, bcd_adj;
  logic [BCW-1:0]        bit_cnt;
  logic [NUM_DIGITS*4-1:0] disp;
  logic                  ovf;
  logic [CW-1:0]         scan_cnt;
  logic [IW-1:0]         dig_idx;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  hi_zero;
  logic [3:0]            cur_nib;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  unused_acc_msb;

  // Conversion state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state: a load is accepted only in IDLE; SHIFT runs BIN_WIDTH cycles
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE:    if (bus.value_valid) begin
                 next_state = SHIFT;
                 load       = 1'b1;
               end
      SHIFT:   if (bit_cnt == BCW'(BIN_WIDTH - 1)) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < ACC_D; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // The accumulator is sized so its top bit never carries anything out
  assign unused_acc_msb = bcd_adj[ACC_D*4-1];

  // Conversion datapath; display and overflow change together only on leaving COMMIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_sr  <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      disp    <= '0;
      ovf     <= 1'b0;
    end else if (load) begin
      bin_sr  <= bus.value;
      bcd     <= '0;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      bcd     <= {bcd_adj[ACC_D*4-2:0], bin_sr[BIN_WIDTH-1]};
      bin_sr  <= bin_sr << 1;
      bit_cnt <= bit_cnt + BCW'(1);
    end else if (state == COMMIT) begin
      disp    <= bcd[NUM_DIGITS*4-1:0];
      ovf     <= |bcd[ACC_D*4-1:NUM_DIGITS*4];
    end
  end

  // Scan timer: hold each digit SCAN_DIV cycles, then step to the next
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == IW'(NUM_DIGITS - 1)) ? '0 : dig_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Leading-zero mask: digit i>0 is dark when it and every higher digit is zero
  always_comb begin
    hi_zero = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero    = hi_zero & (disp[i*4 +: 4] == 4'd0);
      lz_mask[i] = (LZ_BLANK != 0) && (i != 0) && hi_zero;
    end
  end

  assign cur_nib = disp[dig_idx*4 +: 4];

  seg7_digit_decode u_dec (
    .bcd   (cur_nib),
    .blank (lz_mask[dig_idx] & ~ovf),
    .dash  (ovf),
    .seg   (dec_seg)
  );

  // Registered segment/anode outputs; global blank darkens everything without stopping the scan
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_r <= SEG_BLANK;
      an_r  <= '1;
    end else if (bus.blank) begin
      seg_r <= SEG_BLANK;
      an_r  <= '1;
    end else begin
      seg_r <= dec_seg;
      an_r  <= ~(NUM_DIGITS'(1) << dig_idx);
    end
  end

  assign bus.seg      = seg_r;
  assign bus.an       = an_r;
  assign bus.busy     = (state != IDLE);
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit and a 2-digit instance, SCAN_DIV=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(4), .BIN_WIDTH(10)) bus4 ();
  seg7_scan_driver_if #(.NUM_DIGITS(2), .BIN_WIDTH(10)) bus2 ();

  seg7_scan_driver #(.NUM_DIGITS(4), .BIN_WIDTH(10), .SCAN_DIV(4), .LZ_BLANK(1)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4.slave));

  seg7_scan_driver #(.NUM_DIGITS(2), .BIN_WIDTH(10), .SCAN_DIV(4), .LZ_BLANK(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

  localparam logic [6:0] BLK  = 7'b1111111;
  localparam logic [6:0] DASH = 7'b1111110;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic pulse4(input logic [9:0] v);
    bus4.value = v;
    bus4.value_valid = 1'b1;
    @(posedge clk); #1;
    bus4.value_valid = 1'b0;
  endtask

  task automatic pulse2(input logic [9:0] v);
    bus2.value = v;
    bus2.value_valid = 1'b1;
    @(posedge clk); #1;
    bus2.value_valid = 1'b0;
  endtask

  // Count remaining busy cycles (bounded) and compare with the expected count
  task automatic wait_idle4(input string tag, input int exp_len);
    int n = 0;
    while (bus4.busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check(tag, n, exp_len);
  endtask

  task automatic wait_idle2(input string tag, input int exp_len);
    int n = 0;
    while (bus2.busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check(tag, n, exp_len);
  endtask

  // Watch a full scan period and check the segments shown under each one-hot-low anode
  task automatic digits4(input string tag, input logic [3:0][6:0] exp);
    logic [3:0][6:0] s;
    logic [3:0] seen;
    logic [3:0] pat;
    s = '0;
    seen = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        pat = ~(4'b0001 << i);
        if (bus4.an == pat) begin
          s[i] = bus4.seg;
          seen[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_seen%0d", tag, i), seen[i], 1'b1);
      check($sformatf("%s_seg%0d", tag, i), s[i], exp[i]);
    end
  endtask

  task automatic digits2(input string tag, input logic [1:0][6:0] exp);
    logic [1:0][6:0] s;
    logic [1:0] seen;
    logic [1:0] pat;
    s = '0;
    seen = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        pat = ~(2'b01 << i);
        if (bus2.an == pat) begin
          s[i] = bus2.seg;
          seen[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_seen%0d", tag, i), seen[i], 1'b1);
      check($sformatf("%s_seg%0d", tag, i), s[i], exp[i]);
    end
  endtask

  initial begin
    bus4.value = '0; bus4.value_valid = 1'b0; bus4.blank = 1'b0;
    bus2.value = '0; bus2.value_valid = 1'b0; bus2.blank = 1'b0;

    // 1: reset values, then digit 0 shows "0" on the first edge after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", bus4.seg, BLK);
    check("rst_an", bus4.an, 4'b1111);
    check("rst_busy", bus4.busy, 1'b0);
    check("rst_ovf", bus4.overflow, 1'b0);
    check("rst_an2", bus2.an, 2'b11);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_an", bus4.an, 4'b1110);
    check("first_seg", bus4.seg, 7'b0000001);

    // 2: 21, busy for 11 cycles, leading zeros blanked
    pulse4(10'd21);
    wait_idle4("busy_len_21", 11);
    digits4("v21", {BLK, BLK, 7'b0010010, 7'b1001111});

    // 3: 1023, inner zero kept
    pulse4(10'd1023);
    wait_idle4("busy_len_1023", 11);
    check("ovf_1023", bus4.overflow, 1'b0);
    digits4("v1023", {7'b1001111, 7'b0000001, 7'b0010010, 7'b0000110});

    // 4: two-digit instance, overflow then recovery
    pulse2(10'd100);
    wait_idle2("busy_len_100", 11);
    check("ovf_100", bus2.overflow, 1'b1);
    digits2("v100", {DASH, DASH});
    pulse2(10'd7);
    wait_idle2("busy_len_7", 11);
    check("ovf_7", bus2.overflow, 1'b0);
    digits2("v7", {BLK, 7'b0001111});

    // 5: second load during conversion is dropped; then global blank
    pulse4(10'd21);
    repeat (2) @(posedge clk);
    #1;
    pulse4(10'd5);
    wait_idle4("busy_len_drop", 8);
    digits4("drop", {BLK, BLK, 7'b0010010, 7'b1001111});
    check("drop_busy", bus4.busy, 1'b0);
    bus4.blank = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("blank_an%0d", k), bus4.an, 4'b1111);
      check($sformatf("blank_seg%0d", k), bus4.seg, BLK);
    end
    bus4.blank = 1'b0;
    @(posedge clk); #1;
    check("unblank_an", (bus4.an == 4'b1111), 1'b0);

    // 6: reset mid-conversion aborts and clears the display
    pulse4(10'd999);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", bus4.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("arst_seg", bus4.seg, BLK);
    check("arst_an", bus4.an, 4'b1111);
    check("arst_busy", bus4.busy, 1'b0);
    check("arst_ovf", bus4.overflow, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", bus4.busy, 1'b0);
    digits4("post_rst", {BLK, BLK, BLK, 7'b0000001});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
